// File: rtl/seq_gen_controller.sv
// rtl/seq_gen_controller.sv - programmable first/last up/down count sequencer with pass counting
module seq_gen_controller #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_first,
    input  logic [WIDTH-1:0] cfg_last,
    input  logic             cfg_up,
    input  logic [REP_W-1:0] cfg_reps,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            cur_state, nxt_state;
    logic [WIDTH-1:0]  count_n;
    logic              wrap_n, done_n;
    logic [REP_W-1:0]  pass_q, pass_n;
    logic [WIDTH-1:0]  first_q, first_n, last_q, last_n;
    logic              up_q, up_n;
    logic [REP_W-1:0]  reps_q, reps_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_IDLE;
            count     <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            pass_q    <= '0;
            first_q   <= '0;
            last_q    <= '0;
            up_q      <= 1'b0;
            reps_q    <= '0;
        end else begin
            cur_state <= nxt_state;
            count     <= count_n;
            busy      <= (nxt_state == S_RUN);
            wrap      <= wrap_n;
            done      <= done_n;
            pass_q    <= pass_n;
            first_q   <= first_n;
            last_q    <= last_n;
            up_q      <= up_n;
            reps_q    <= reps_n;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        count_n   = count;
        wrap_n    = 1'b0;
        done_n    = 1'b0;
        pass_n    = pass_q;
        first_n   = first_q;
        last_n    = last_q;
        up_n      = up_q;
        reps_n    = reps_q;

        if (abort) begin
            nxt_state = S_IDLE;
            count_n   = '0;
            pass_n    = '0;
        end else begin
            case (cur_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        first_n   = cfg_first;
                        last_n    = cfg_last;
                        up_n      = cfg_up;
                        reps_n    = cfg_reps;
                        count_n   = cfg_first;
                        pass_n    = '0;
                        nxt_state = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        if (count != last_q) begin
                            count_n = up_q ? count + WIDTH'(1) : count - WIDTH'(1);
                        end else if (reps_q != '0 && (pass_q + REP_W'(1)) == reps_q) begin
                            nxt_state = S_DONE;
                            done_n    = 1'b1;
                        end else begin
                            count_n = first_q;
                            wrap_n  = 1'b1;
                            // Saturate so an endless run (reps=0) never rolls the counter over.
                            if (pass_q != '1) pass_n = pass_q + REP_W'(1);
                        end
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                    count_n   = '0;
                    pass_n    = '0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: doc/seq_gen_controller.md
Name: seq_gen_controller

Overview:
- Sequences a programmable WIDTH-bit count sequence for the sequence-generator datapath.
- Runs from a latched first value to a latched last value in a chosen direction, for a programmable number of passes.
- Supports start, pause and abort control, and reports busy, wrap and done status.
- Sits between the control logic or testbench and downstream logic that consumes `count`.

Parameters:
- WIDTH, 4, width of count, cfg_first and cfg_last.
- REP_W, 4, width of cfg_reps and of the internal pass counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a run; sampled on clk.
- pause  input  1  level; holds the sequence while high in RUN.
- abort  input  1  forces IDLE; highest-priority control.
- cfg_first  input  WIDTH  first value of each pass.
- cfg_last  input  WIDTH  last value of each pass.
- cfg_up  input  1  direction: 1 = increment, 0 = decrement.
- cfg_reps  input  REP_W  number of passes; 0 = run forever.
- count  output  WIDTH  current sequence value (registered).
- busy  output  1  high while state is RUN.
- wrap  output  1  one-cycle pulse when count reloads last->first.
- done  output  1  one-cycle pulse on entry to DONE.
- state  output  2  IDLE=0, RUN=1, DONE=2.

Behaviour:
- All outputs are registered.
- On reset assertion, immediately and without a clock edge: state=IDLE, count=0, busy=0, wrap=0, done=0, pass counter=0, shadow config=0.
- States are IDLE, RUN and DONE; encoding 3 is unreachable and recovers to IDLE on the next edge.
- Control priority per edge: abort > start > pause.
- abort (any state): next state IDLE, count=0, busy=0, wrap=0, done=0, pass counter cleared.
- start in IDLE or DONE:
  - latch cfg_first, cfg_last, cfg_up, cfg_reps into shadow registers.
  - count<=cfg_first, pass counter<=0, state<=RUN, busy<=1, all on the same edge.
  - Latency from the start edge to the first valid count is 0 cycles.
- start in RUN is ignored.
- cfg_* changes after the start edge have no effect until the next accepted start.
- RUN with pause=1: count, pass counter and state hold; busy stays 1; wrap=0.
- RUN with pause=0 and count != last: count <= count+1 if up, else count-1, modulo 2^WIDTH.
  - Example, up: first=12, last=3 steps 12,13,14,15,0,1,2,3.
- RUN with pause=0 and count == last (pass complete):
  - If reps != 0 and pass counter+1 == reps: state<=DONE, count holds last, done<=1 for exactly one cycle, busy<=0.
  - Otherwise: count<=first, wrap<=1 for one cycle, pass counter increments.
  - When reps=0 the pass counter saturates at all-ones; it is not used.
- first == last: every RUN cycle completes one pass.
  - reps=N gives N cycles of count=first in RUN, then DONE.
- wrap and done are never high together.
- wrap and done are 0 in any cycle not explicitly defined above.
- DONE: count holds its last value; busy=0. DONE exits only on start (new run) or abort (IDLE).
- IDLE: count=0, busy=0; only start leaves IDLE.
- Reset asserted mid-run overrides everything, asynchronously. After deassertion the block waits in IDLE for start.

Test Plan:
- Reset in the middle of RUN, asserted between clock edges -> count=0, state=0, busy=0 before the next edge. No activity after release until start.
- first=2, last=5, up=1, reps=2; start for 1 cycle -> count 2,3,4,5,2,3,4,5 on consecutive edges. wrap high only with the second 2. done high for one cycle on entry to DONE with count=5. busy low from that cycle on.
- first=1, last=14, up=0, reps=1 -> count 1,0,15,14, then DONE with count=14 and a done pulse; no wrap pulse.
- first=0, last=9, up=1, reps=1; pause high for 3 cycles when count=3 -> count reads 3 for 4 consecutive cycles, then continues 4..9 and done.
- During RUN: assert start with new cfg -> ignored, sequence unchanged. Then assert abort and start in the same cycle -> IDLE, count=0, busy=0.
- first=last=7, reps=0 -> count stays 7, wrap high every cycle after the first, done never asserts over 50 cycles. abort then returns to IDLE.
